// File: rtl/parking_gate_ctrl.sv
// Barrier gate sequencer for a shared entry/exit lane: arbitration, motor phases, lot occupancy.
// Build option: define EXIT_PRIORITY_EN for fixed exit-wins-tie arbitration (default is round-robin).
module parking_gate_ctrl #(
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned OPEN_TICKS = 2,
  parameter int unsigned HOLD_TICKS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             gate_up,
  output logic             gate_down,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             full_led,
  output logic             busy
);

  localparam int unsigned MAX_TICKS = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
  localparam int unsigned TMR_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_TICKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic [CNT_W-1:0] occ_next;
  logic             grant_entry_next;
  logic             grant_exit_next;
  logic             entry_valid;
  logic             exit_valid;
  logic             pick_exit;
`ifndef EXIT_PRIORITY_EN
  logic             last_exit;
  logic             last_exit_next;
`endif

  // Next-state, grant, occupancy and phase-timer logic
  always_comb begin
    state_next       = state;
    grant_entry_next = grant_entry;
    grant_exit_next  = grant_exit;
    occ_next         = occupancy;
    pick_exit        = 1'b0;
`ifndef EXIT_PRIORITY_EN
    last_exit_next   = last_exit;
`endif
    entry_valid      = entry_req && !full;
    exit_valid       = exit_req && (occupancy != '0);

    case (state)
      IDLE: begin
        if (entry_valid || exit_valid) begin
`ifdef EXIT_PRIORITY_EN
          pick_exit      = exit_valid;
`else
          pick_exit      = exit_valid && (!entry_valid || !last_exit);
          last_exit_next = pick_exit;
`endif
          grant_exit_next  = pick_exit;
          grant_entry_next = !pick_exit;
          state_next       = OPENING;
        end
      end
      OPENING: begin
        if (tick_1hz && (timer == OPEN_LAST)) state_next = OPEN_HOLD;
      end
      OPEN_HOLD: begin
        // A car_passed coinciding with the last hold tick still counts
        if (car_passed) begin
          if (grant_entry) begin
            if (occupancy != CAP_VAL) occ_next = occupancy + CNT_W'(1);
          end else if (occupancy != '0) begin
            occ_next = occupancy - CNT_W'(1);
          end
          state_next = CLOSING;
        end else if (tick_1hz && (timer == HOLD_LAST)) begin
          state_next = CLOSING;
        end
      end
      CLOSING: begin
        if (tick_1hz && (timer == OPEN_LAST)) begin
          state_next       = IDLE;
          grant_entry_next = 1'b0;
          grant_exit_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) timer_next = '0;
    else if (tick_1hz)       timer_next = timer + TMR_W'(1);
    else                     timer_next = timer;
  end

  // State register and registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      gate_up     <= 1'b0;
      gate_down   <= 1'b0;
      gate_open   <= 1'b0;
      busy        <= 1'b0;
      occupancy   <= '0;
      full        <= 1'b0;
      full_led    <= 1'b0;
`ifndef EXIT_PRIORITY_EN
      last_exit   <= 1'b1;
`endif
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      grant_entry <= grant_entry_next;
      grant_exit  <= grant_exit_next;
      gate_up     <= (state_next == OPENING);
      gate_open   <= (state_next == OPEN_HOLD);
      gate_down   <= (state_next == CLOSING);
      busy        <= (state_next != IDLE);
      occupancy   <= occ_next;
      full        <= (occ_next == CAP_VAL);
      if (!full)         full_led <= 1'b0;
      else if (tick_2hz) full_led <= !full_led;
`ifndef EXIT_PRIORITY_EN
      last_exit   <= last_exit_next;
`endif
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed self-checking bench for parking_gate_ctrl (CAPACITY=2, OPEN_TICKS=2, HOLD_TICKS=3).
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       car_passed = 1'b0;
  logic       grant_entry, grant_exit, gate_up, gate_down, gate_open;
  logic [3:0] occupancy;
  logic       full, full_led, busy;

  int compared = 0;
  int mismatched = 0;
  int tick_cnt = 0;
  int n;
  int toggles;
  logic prev_led;

  parking_gate_ctrl #(
    .CAPACITY(2), .CNT_W(4), .OPEN_TICKS(2), .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
    .grant_entry(grant_entry), .grant_exit(grant_exit), .gate_up(gate_up),
    .gate_down(gate_down), .gate_open(gate_open), .occupancy(occupancy),
    .full(full), .full_led(full_led), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tick enables: 1 Hz every 10 clk, 2 Hz every 5 clk, one clk wide
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_cnt++;
      tick_1hz = (tick_cnt % 10 == 0);
      tick_2hz = (tick_cnt % 5 == 0);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return busy;
      1: return gate_open;
      2: return gate_down;
      default: return gate_up;
    endcase
  endfunction

  task automatic wait_for(input int s, input logic v, input int maxc, output int cyc);
    cyc = 0;
    while (sig(s) !== v && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One full gate cycle for the given requests, optionally passing a car in hold
  task automatic run_txn(input string tag, input logic ent, input logic ex, input logic pass);
    int c;
    entry_req = ent;
    exit_req  = ex;
    step(1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    chk({tag, "_busy"}, 8'(busy), 8'd1);
    wait_for(1, 1'b1, 40, c);
    chk({tag, "_open_reached"}, 8'(gate_open), 8'd1);
    if (pass) begin
      step(3);
      car_passed = 1'b1;
      step(1);
      car_passed = 1'b0;
    end
    wait_for(0, 1'b0, 80, c);
    chk({tag, "_idle_reached"}, 8'(busy), 8'd0);
  endtask

  initial begin
    // 1: reset held for 3 clk
    step(3);
    chk("rst_occ", 8'(occupancy), 8'd0);
    chk("rst_grants", 8'({grant_entry, grant_exit}), 8'd0);
    chk("rst_gate", 8'({gate_up, gate_down, gate_open}), 8'd0);
    chk("rst_busy_full", 8'({busy, full, full_led}), 8'd0);
    reset = 1'b0;
    step(2);

    // 2: single entry with car passing mid-hold
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
    chk("e1_grant_entry", 8'(grant_entry), 8'd1);
    chk("e1_grant_exit", 8'(grant_exit), 8'd0);
    chk("e1_gate_up", 8'(gate_up), 8'd1);
    chk("e1_busy", 8'(busy), 8'd1);
    wait_for(1, 1'b1, 40, n);
    chk("e1_open_time_ok", 8'(n >= 11 && n <= 20), 8'd1);
    chk("e1_up_off_in_hold", 8'(gate_up), 8'd0);
    step(3);
    car_passed = 1'b1;
    step(1);
    car_passed = 1'b0;
    chk("e1_gate_down", 8'(gate_down), 8'd1);
    chk("e1_occ_counted", 8'(occupancy), 8'd1);
    wait_for(0, 1'b0, 40, n);
    chk("e1_close_time_ok", 8'(n >= 10 && n <= 20), 8'd1);
    chk("e1_grant_dropped", 8'(grant_entry), 8'd0);
    chk("e1_occ", 8'(occupancy), 8'd1);

    // 3: fill the lot, entry then refused, full_led blinking
    run_txn("e2", 1'b1, 1'b0, 1'b1);
    chk("e2_occ", 8'(occupancy), 8'd2);
    chk("e2_full", 8'(full), 8'd1);
    entry_req = 1'b1;
    step(3);
    chk("full_no_grant", 8'(grant_entry), 8'd0);
    chk("full_not_busy", 8'(busy), 8'd0);
    entry_req = 1'b0;
    toggles = 0;
    prev_led = full_led;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (full_led !== prev_led) toggles++;
      prev_led = full_led;
    end
    chk("full_led_toggles", 8'(toggles), 8'd4);
    run_txn("x1", 1'b0, 1'b1, 1'b1);
    chk("x1_occ", 8'(occupancy), 8'd1);
    chk("x1_not_full", 8'(full), 8'd0);
    chk("x1_led_off", 8'(full_led), 8'd0);

    // 5: entry granted, no car -> closes after 3rd hold tick, occupancy unchanged
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
    chk("e3_grant_entry", 8'(grant_entry), 8'd1);
    wait_for(1, 1'b1, 40, n);
    wait_for(2, 1'b1, 50, n);
    chk("e3_hold_time_ok", 8'(n >= 21 && n <= 30), 8'd1);
    chk("e3_occ_same", 8'(occupancy), 8'd1);
    wait_for(0, 1'b0, 40, n);
    chk("e3_idle", 8'(busy), 8'd0);

    // 4: tie with last grant entry -> exit wins
    entry_req = 1'b1;
    exit_req  = 1'b1;
    step(1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    chk("tie_grant_exit", 8'(grant_exit), 8'd1);
    chk("tie_no_entry", 8'(grant_entry), 8'd0);
    wait_for(0, 1'b0, 100, n);
    chk("tie_idle", 8'(busy), 8'd0);
    chk("tie_occ_same", 8'(occupancy), 8'd1);

    // 6: reset pulse during OPENING
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
    step(3);
    chk("r_opening", 8'(gate_up), 8'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("r_gate_up", 8'(gate_up), 8'd0);
    chk("r_grants", 8'({grant_entry, grant_exit}), 8'd0);
    chk("r_occ", 8'(occupancy), 8'd0);
    chk("r_busy", 8'(busy), 8'd0);
    step(3);
    chk("r_stays_idle", 8'(busy), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
